// File: rtl/cnn_pkg.sv
// Shared CNN datapath types, default feature-map geometry and the unpool FSM encoding.
package cnn_pkg;
  localparam int DATA_W        = 32;
  localparam int FM_WIDTH_DEF  = 6;
  localparam int FM_HEIGHT_DEF = 6;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_SCALE = 4'd2;
  localparam logic [3:0] S_WRITE = 4'd3;
  localparam logic [3:0] S_NEXT  = 4'd4;
  localparam logic [3:0] S_DONE  = 4'd5;
endpackage

// File: rtl/unpool_layer_if.sv
// Launch/complete handshake plus pooled-input and upsampled-output maps of the unpool layer.
interface unpool_layer_if #(
  parameter int FM_WIDTH  = cnn_pkg::FM_WIDTH_DEF,
  parameter int FM_HEIGHT = cnn_pkg::FM_HEIGHT_DEF
);
  localparam int N_IN  = (FM_WIDTH/2)*(FM_HEIGHT/2);
  localparam int N_OUT = FM_WIDTH*FM_HEIGHT;

  logic                              start;
  logic                              done;
  cnn_pkg::data_t [N_IN-1:0]         input_fm;
  cnn_pkg::data_t [N_OUT-1:0]        output_fm;

  modport master (output start, output input_fm, input done, input output_fm);
  modport slave  (input start, input input_fm, output done, output output_fm);
endinterface

// File: rtl/avg_unpool_unit.sv
// Registered scale stage, one-cycle latency. UNPOOL_AVG_SCALE_EN selects divide-by-4
// (arithmetic shift, average-pool backward pass); otherwise the value passes unchanged.
module avg_unpool_unit
  import cnn_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  data_t value,
  input  logic  enable,
  output data_t result
);
  data_t scaled;

`ifdef UNPOOL_AVG_SCALE_EN
  // Floor toward minus infinity: -5 -> -2, -1 -> -1.
  assign scaled = $signed(value) >>> 2;
`else
  assign scaled = value;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        result <= '0;
    else if (enable) result <= scaled;
  end
endmodule

// File: rtl/unpool_layer.sv
// 2x2 unpooling: each pooled element is scaled and replicated into its output block,
// 4 cycles per element. Scaling selected by UNPOOL_AVG_SCALE_EN (see avg_unpool_unit).
module unpool_layer
  import cnn_pkg::*;
#(
  parameter int FM_WIDTH  = FM_WIDTH_DEF,
  parameter int FM_HEIGHT = FM_HEIGHT_DEF
)(
  input logic           clk,
  input logic           rst,
  unpool_layer_if.slave bus
);
  localparam int N_IN  = (FM_WIDTH/2)*(FM_HEIGHT/2);
  localparam int N_OUT = FM_WIDTH*FM_HEIGHT;
  localparam int KW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [KW-1:0] K_LAST   = KW'(N_IN-1);
  localparam logic [OW-1:0] COL_LAST = OW'(FM_WIDTH-2);
  localparam logic [OW-1:0] ROW_STEP = OW'(2*FM_WIDTH);
  localparam logic [OW-1:0] W_OFF    = OW'(FM_WIDTH);

  logic [3:0]             state;
  logic [KW-1:0]          k;
  logic [OW-1:0]          row_base;
  logic [OW-1:0]          col_off;
  logic [OW-1:0]          base;
  logic                   done_q;
  logic                   load_en;
  data_t                  scaled;
  data_t [N_OUT-1:0]      out_q;

  // Block origin tracked incrementally (row_base + col_off) to avoid a divider on k.
  assign base    = row_base + col_off;
  assign load_en = (state == S_LOAD);

  avg_unpool_unit u_scale (
    .clk    (clk),
    .rst    (rst),
    .value  (bus.input_fm[k]),
    .enable (load_en),
    .result (scaled)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      k        <= '0;
      row_base <= '0;
      col_off  <= '0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            done_q   <= 1'b0;
            k        <= '0;
            row_base <= '0;
            col_off  <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD:  state <= S_SCALE;
        S_SCALE: state <= S_WRITE;
        S_WRITE: state <= S_NEXT;
        S_NEXT: begin
          if (k < K_LAST) begin
            k <= k + 1'b1;
            if (col_off == COL_LAST) begin
              col_off  <= '0;
              row_base <= row_base + ROW_STEP;
            end else begin
              col_off  <= col_off + OW'(2);
            end
            state <= S_LOAD;
          end else begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Entries outside the current block keep their value from any earlier run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else if (state == S_WRITE) begin
      out_q[base]                 <= scaled;
      out_q[base + OW'(1)]        <= scaled;
      out_q[base + W_OFF]         <= scaled;
      out_q[base + W_OFF + OW'(1)] <= scaled;
    end
  end

  assign bus.done      = done_q;
  assign bus.output_fm = out_q;
endmodule

// File: tb/tb_unpool_layer.sv
// Directed bench for unpool_layer at 6x6; expected values follow UNPOOL_AVG_SCALE_EN.
module tb_unpool_layer;
  import cnn_pkg::*;

  localparam int W = 6, H = 6, N_IN = 9, N_OUT = 36;

`ifdef UNPOOL_AVG_SCALE_EN
  localparam int A0 = 1, A8 = 9, B0 = -2, B1 = -1, B4 = 0, B8 = 32'h1FFFFFFF;
`else
  localparam int A0 = 4, A8 = 36, B0 = -5, B1 = -1, B4 = 3, B8 = 32'h7FFFFFFF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;
  int   in_v [N_IN];

  unpool_layer_if #(.FM_WIDTH(W), .FM_HEIGHT(H)) bus ();
  unpool_layer #(.FM_WIDTH(W), .FM_HEIGHT(H)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int get_out(input int i);
    logic [5:0] ix;
    ix = 6'(i);
    return int'(bus.output_fm[ix]);
  endfunction

  function automatic int nz_count();
    int n = 0;
    for (int i = 0; i < N_OUT; i++) if (get_out(i) != 0) n++;
    return n;
  endfunction

  function automatic int sc(input int v);
`ifdef UNPOOL_AVG_SCALE_EN
    return v >>> 2;
`else
    return v;
`endif
  endfunction

  // Output index -> source element: output row/2 selects input row, column/2 input column.
  function automatic int exp_out(input int i);
    return sc(in_v[((i / W) / 2) * (W / 2) + (i % W) / 2]);
  endfunction

  task automatic apply_in();
    for (int e = 0; e < N_IN; e++) bus.input_fm[4'(e)] = in_v[e];
  endtask

  task automatic set_a();
    for (int e = 0; e < N_IN; e++) in_v[e] = 4 * (e + 1);
    apply_in();
  endtask

  task automatic set_b();
    for (int e = 0; e < N_IN; e++) in_v[e] = 0;
    in_v[0] = -5; in_v[1] = -1; in_v[4] = 3; in_v[8] = 32'h7FFFFFFF;
    apply_in();
  endtask

  task automatic chk_blk(input string tag, input int b, input int exp);
    chk({tag, "_0"}, get_out(b),         exp);
    chk({tag, "_1"}, get_out(b + 1),     exp);
    chk({tag, "_W"}, get_out(b + W),     exp);
    chk({tag, "_W1"}, get_out(b + W + 1), exp);
  endtask

  task automatic chk_map(input string tag);
    for (int i = 0; i < N_OUT; i++) chk($sformatf("%s[%0d]", tag, i), get_out(i), exp_out(i));
  endtask

  // Pulse (or hold) start, then check done is low after edge N+35 and high after N+36.
  task automatic run(input string tag, input bit hold);
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    if (!hold) #1 bus.start = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk) chk({tag, "_done_n35"}, int'(bus.done), 0);
    @(posedge clk);
    @(negedge clk) chk({tag, "_done_n36"}, int'(bus.done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start    = 1'b0;
    bus.input_fm = '0;
    #12;
    chk("rst_done", int'(bus.done), 0);
    chk("rst_zero", nz_count(), 0);

    // Idle: no start for 50 cycles
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 50; c++) @(negedge clk) chk($sformatf("idle_done_%0d", c), int'(bus.done), 0);
    chk("idle_zero", nz_count(), 0);

    // Run A: 4,8,...,36
    set_a();
    run("A", 1'b0);
    chk_blk("A_blk0", 0, A0);
    chk_blk("A_blk8", 28, A8);
    chk_map("A_map");

    // Run B relaunched from DONE; later blocks keep run-A values until rewritten
    set_b();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("B_mid_done", int'(bus.done), 0);
    chk("B_mid_blk0", get_out(0), B0);
    chk("B_mid_keep28", get_out(28), A8);
    repeat (31) @(posedge clk);
    @(negedge clk) chk("B_done_n35", int'(bus.done), 0);
    @(posedge clk);
    @(negedge clk) chk("B_done_n36", int'(bus.done), 1);
    chk_blk("B_blk0", 0, B0);
    chk_blk("B_blk1", 2, B1);
    chk_blk("B_blk4", 14, B4);
    chk_blk("B_blk8", 28, B8);
    chk_map("B_map");

    // Reset at edge N+15 of a run
    set_a();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("R_done", int'(bus.done), 0);
    chk("R_zero", nz_count(), 0);
    @(negedge clk);
    chk("R_hold_done", int'(bus.done), 0);
    rst = 1'b1;
    run("R", 1'b0);
    chk_map("R_map");

    // Start held high: no mid-run restart, relaunch on the edge after done
    set_b();
    run("H", 1'b1);
    @(posedge clk);
    @(negedge clk) chk("H_relaunch_done", int'(bus.done), 0);
    bus.start = 1'b0;
    repeat (35) @(posedge clk);
    @(negedge clk) chk("H2_done_n35", int'(bus.done), 0);
    @(posedge clk);
    @(negedge clk) chk("H2_done_n36", int'(bus.done), 1);
    chk_map("H_map");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
